// File: rtl/rtc_display_pkg.sv
// Shared constants, FSM encoding and BCD helpers for the RTC display register block.
// The WAIT_FRAME state exists only when SHADOW_VSYNC_EN is defined.
package rtc_display_pkg;

    localparam logic [3:0] ADDR_SS   = 4'd0;
    localparam logic [3:0] ADDR_MM   = 4'd1;
    localparam logic [3:0] ADDR_HH   = 4'd2;
    localparam logic [3:0] ADDR_DAY  = 4'd3;
    localparam logic [3:0] ADDR_MES  = 4'd4;
    localparam logic [3:0] ADDR_YEAR = 4'd5;
    localparam logic [3:0] ADDR_SS_T = 4'd6;
    localparam logic [3:0] ADDR_MM_T = 4'd7;
    localparam logic [3:0] ADDR_HH_T = 4'd8;
    localparam logic [3:0] ADDR_WDAY = 4'd9;
    localparam logic [3:0] ADDR_CTRL = 4'd10;

    localparam int NUM_FIELDS = 9;

    localparam logic [7:0] SS_MAX   = 8'd59;
    localparam logic [7:0] MM_MAX   = 8'd59;
    localparam logic [7:0] HH_MAX   = 8'd23;
    localparam logic [7:0] DAY_MIN  = 8'd1;
    localparam logic [7:0] DAY_MAX  = 8'd31;
    localparam logic [7:0] MES_MIN  = 8'd1;
    localparam logic [7:0] MES_MAX  = 8'd12;
    localparam logic [7:0] YEAR_MAX = 8'd99;
    localparam logic [7:0] WDAY_MIN = 8'd1;
    localparam logic [7:0] WDAY_MAX = 8'd7;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_CONVERT,
        ST_APPLY
`ifdef SHADOW_VSYNC_EN
        , ST_WAIT_FRAME
`endif
    } state_t;

    typedef struct packed {
        logic [3:0] tens;
        logic [3:0] units;
    } bcd_pair_t;

    function automatic logic [7:0] bcd_to_bin(input bcd_pair_t b);
        return 8'(b.tens) * 8'd10 + 8'(b.units);
    endfunction

    function automatic bcd_pair_t bin_to_bcd(input logic [7:0] v);
        bcd_pair_t r;
        r.tens  = 4'(v / 8'd10);
        r.units = 4'(v % 8'd10);
        return r;
    endfunction

    function automatic logic bcd_in_range(input bcd_pair_t b, input logic [7:0] lo,
                                          input logic [7:0] hi);
        logic [7:0] v;
        v = bcd_to_bin(b);
        return (b.tens <= 4'd9) && (b.units <= 4'd9) && (v >= lo) && (v <= hi);
    endfunction

    function automatic logic [7:0] field_min(input int idx);
        case (idx)
            3:       return DAY_MIN;
            4:       return MES_MIN;
            default: return 8'd0;
        endcase
    endfunction

    function automatic logic [7:0] field_max(input int idx);
        case (idx)
            0, 6:    return SS_MAX;
            1, 7:    return MM_MAX;
            2, 8:    return HH_MAX;
            3:       return DAY_MAX;
            4:       return MES_MAX;
            default: return YEAR_MAX;
        endcase
    endfunction

endpackage

// File: rtl/rtc_display_regs_bcd_hour_12h.sv
// Combinational BCD hour check (00..23) and optional 24 h to 12 h conversion with AM/PM.
import rtc_display_pkg::*;

module bcd_hour_12h (
    input  bcd_pair_t i_hour,
    input  logic      i_fmt_12h,
    output bcd_pair_t o_hour,
    output logic      o_am_pm,
    output logic      o_err
);

    logic [7:0] w_bin;
    assign w_bin = bcd_to_bin(i_hour);

    // NOTE: every output gets a default first so no path can infer a latch.
    always_comb begin
        o_err   = !bcd_in_range(i_hour, 8'd0, HH_MAX);
        o_hour  = i_hour;
        o_am_pm = 1'b0;
        if (i_fmt_12h) begin
            if (w_bin == 8'd0) begin
                o_hour = bin_to_bcd(8'd12);
            end else if (w_bin >= 8'd12) begin
                o_am_pm = 1'b1;
                if (w_bin > 8'd12) o_hour = bin_to_bcd(w_bin - 8'd12);
            end
        end
    end

endmodule

// File: rtl/rtc_display_regs.sv
// Shadow registers with atomic commit to the clock-screen digit outputs, plus timer alarm.
// Define SHADOW_VSYNC_EN to defer each commit to the next vsync falling edge.
import rtc_display_pkg::*;

module rtc_display_regs #(
    parameter logic [31:0] ALARM_TIMEOUT_CYC = 32'd3000000000,
    parameter int          CNT_W             = 32
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       wr_en,
    input  logic [3:0] wr_addr,
    input  logic [7:0] wr_data,
    input  logic       commit,
    input  logic       alarm_ack,
    input  logic       vsync,
    output logic [3:0] digit1_HH,   output logic [3:0] digit0_HH,
    output logic [3:0] digit1_MM,   output logic [3:0] digit0_MM,
    output logic [3:0] digit1_SS,   output logic [3:0] digit0_SS,
    output logic [3:0] digit1_DAY,  output logic [3:0] digit0_DAY,
    output logic [3:0] digit1_MES,  output logic [3:0] digit0_MES,
    output logic [3:0] digit1_YEAR, output logic [3:0] digit0_YEAR,
    output logic [3:0] digit1_HH_T, output logic [3:0] digit0_HH_T,
    output logic [3:0] digit1_MM_T, output logic [3:0] digit0_MM_T,
    output logic [3:0] digit1_SS_T, output logic [3:0] digit0_SS_T,
    output logic       AM_PM,
    output logic [7:0] dia_semana,
    output logic       formato_hora,
    output logic       estado_alarma,
    output logic       update_done,
    output logic       bcd_err
);

    localparam logic [CNT_W-1:0] TIMEOUT_M1 = CNT_W'(ALARM_TIMEOUT_CYC - 32'd1);
    localparam logic             TIMEOUT_EN = (ALARM_TIMEOUT_CYC != 32'd0);

    state_t    r_state, w_next;
    logic      r_pending;
    logic      w_snap_en, w_convert, w_apply, w_pend_set, w_pend_clr;

    bcd_pair_t r_shadow [NUM_FIELDS];
    bcd_pair_t r_snap   [NUM_FIELDS];
    bcd_pair_t r_out    [NUM_FIELDS];
    bcd_pair_t w_new_out[NUM_FIELDS];
    logic [7:0] r_shadow_wday, r_snap_wday, r_wday;
    logic       r_shadow_fmt, r_snap_fmt, r_fmt;

    logic [NUM_FIELDS-1:0] w_ok, r_ok;
    logic       w_wday_ok, r_wday_ok;
    bcd_pair_t  w_hh_conv, r_conv_hh;
    logic       w_hh_ampm, r_conv_ampm, w_hh_err, r_ampm;

    logic             r_alarm, w_alarm_set;
    logic [CNT_W-1:0] r_cnt;
    logic             r_update_done, r_bcd_err;

`ifdef SHADOW_VSYNC_EN
    localparam state_t ST_ACCEPT = ST_WAIT_FRAME;
    logic r_vsync_q, w_vsync_fall;
    assign w_vsync_fall = r_vsync_q & ~vsync;
    always_ff @(posedge clock or posedge reset) begin
        if (reset) r_vsync_q <= 1'b1;
        else       r_vsync_q <= vsync;
    end
`else
    localparam state_t ST_ACCEPT = ST_CONVERT;
    logic w_unused_vsync;
    assign w_unused_vsync = vsync;
`endif

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state   <= ST_IDLE;
            r_pending <= 1'b0;
        end else begin
            r_state <= w_next;
            if (w_pend_clr)      r_pending <= 1'b0;
            else if (w_pend_set) r_pending <= 1'b1;
        end
    end

    always_comb begin
        w_next     = r_state;
        w_snap_en  = 1'b0;
        w_convert  = 1'b0;
        w_apply    = 1'b0;
        w_pend_set = 1'b0;
        w_pend_clr = 1'b0;
        case (r_state)
            ST_IDLE: if (commit) begin
                w_snap_en = 1'b1;
                w_next    = ST_ACCEPT;
            end
`ifdef SHADOW_VSYNC_EN
            ST_WAIT_FRAME: begin
                w_pend_set = commit;
                if (w_vsync_fall) w_next = ST_CONVERT;
            end
`endif
            ST_CONVERT: begin
                w_convert  = 1'b1;
                w_pend_set = commit;
                w_next     = ST_APPLY;
            end
            ST_APPLY: begin
                w_apply = 1'b1;
                if (r_pending || commit) begin
                    w_snap_en  = 1'b1;
                    w_pend_clr = 1'b1;
                    w_next     = ST_ACCEPT;
                end else begin
                    w_next = ST_IDLE;
                end
            end
            default: w_next = ST_IDLE;
        endcase
    end

    // NOTE: these small register arrays are flops, not RAM, so they are reset element by element.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NUM_FIELDS; i++) begin
                r_shadow[i] <= '0;
                r_snap[i]   <= '0;
            end
            r_shadow_wday <= 8'd1;
            r_snap_wday   <= 8'd1;
            r_shadow_fmt  <= 1'b0;
            r_snap_fmt    <= 1'b0;
        end else begin
            if (w_snap_en) begin
                for (int i = 0; i < NUM_FIELDS; i++) r_snap[i] <= r_shadow[i];
                r_snap_wday <= r_shadow_wday;
                r_snap_fmt  <= r_shadow_fmt;
            end
            if (wr_en) begin
                if (wr_addr <= ADDR_HH_T)      r_shadow[wr_addr] <= wr_data;
                else if (wr_addr == ADDR_WDAY) r_shadow_wday     <= wr_data;
                else if (wr_addr == ADDR_CTRL) r_shadow_fmt      <= wr_data[0];
            end
        end
    end

    bcd_hour_12h u_hour (
        .i_hour    (r_snap[ADDR_HH]),
        .i_fmt_12h (r_snap_fmt),
        .o_hour    (w_hh_conv),
        .o_am_pm   (w_hh_ampm),
        .o_err     (w_hh_err)
    );

    always_comb begin
        for (int i = 0; i < NUM_FIELDS; i++) begin
            w_ok[i]      = bcd_in_range(r_snap[i], field_min(i), field_max(i));
            w_new_out[i] = r_ok[i] ? r_snap[i] : r_out[i];
        end
        w_ok[ADDR_HH] = !w_hh_err;
        if (r_ok[ADDR_HH]) w_new_out[ADDR_HH] = r_conv_hh;
        w_wday_ok = (r_snap_wday >= WDAY_MIN) && (r_snap_wday <= WDAY_MAX);
    end

    // A rejected timer field keeps its held value, which is what the zero compare sees.
    assign w_alarm_set = w_apply
                       && ({r_out[ADDR_SS_T], r_out[ADDR_MM_T], r_out[ADDR_HH_T]} != '0)
                       && ({w_new_out[ADDR_SS_T], w_new_out[ADDR_MM_T], w_new_out[ADDR_HH_T]} == '0);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_ok          <= '0;
            r_wday_ok     <= 1'b0;
            r_conv_hh     <= '0;
            r_conv_ampm   <= 1'b0;
            for (int i = 0; i < NUM_FIELDS; i++) r_out[i] <= '0;
            r_ampm        <= 1'b0;
            r_wday        <= 8'd1;
            r_fmt         <= 1'b0;
            r_update_done <= 1'b0;
            r_bcd_err     <= 1'b0;
        end else begin
            if (w_convert) begin
                r_ok        <= w_ok;
                r_wday_ok   <= w_wday_ok;
                r_conv_hh   <= w_hh_conv;
                r_conv_ampm <= w_hh_ampm;
            end
            r_update_done <= w_apply;
            r_bcd_err     <= w_apply && (!(&r_ok) || !r_wday_ok);
            if (w_apply) begin
                for (int i = 0; i < NUM_FIELDS; i++) r_out[i] <= w_new_out[i];
                if (r_ok[ADDR_HH]) r_ampm <= r_conv_ampm;
                if (r_wday_ok)     r_wday <= r_snap_wday;
                r_fmt <= r_snap_fmt;
            end
        end
    end

    // Set beats ack; the timeout counter restarts on every set.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_alarm <= 1'b0;
            r_cnt   <= '0;
        end else if (w_alarm_set) begin
            r_alarm <= 1'b1;
            r_cnt   <= '0;
        end else if (r_alarm) begin
            if (alarm_ack || (TIMEOUT_EN && r_cnt == TIMEOUT_M1)) begin
                r_alarm <= 1'b0;
                r_cnt   <= '0;
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

    assign {digit1_SS,   digit0_SS}   = r_out[ADDR_SS];
    assign {digit1_MM,   digit0_MM}   = r_out[ADDR_MM];
    assign {digit1_HH,   digit0_HH}   = r_out[ADDR_HH];
    assign {digit1_DAY,  digit0_DAY}  = r_out[ADDR_DAY];
    assign {digit1_MES,  digit0_MES}  = r_out[ADDR_MES];
    assign {digit1_YEAR, digit0_YEAR} = r_out[ADDR_YEAR];
    assign {digit1_SS_T, digit0_SS_T} = r_out[ADDR_SS_T];
    assign {digit1_MM_T, digit0_MM_T} = r_out[ADDR_MM_T];
    assign {digit1_HH_T, digit0_HH_T} = r_out[ADDR_HH_T];
    assign AM_PM         = r_ampm;
    assign dia_semana    = r_wday;
    assign formato_hora  = r_fmt;
    assign estado_alarma = r_alarm;
    assign update_done   = r_update_done;
    assign bcd_err       = r_bcd_err;

endmodule

// File: tb/tb_rtc_display_regs.sv
// Bench for rtc_display_regs: directed literal checks plus a randomized run against a
// behavioural model compared on every negative clock edge.
module tb_rtc_display_regs;

    localparam logic [31:0] TMO = 32'd10;

    logic       clock = 1'b0;
    logic       reset, wr_en, commit, alarm_ack, vsync;
    logic [3:0] wr_addr;
    logic [7:0] wr_data;
    logic [3:0] d1_hh, d0_hh, d1_mm, d0_mm, d1_ss, d0_ss, d1_day, d0_day, d1_mes, d0_mes;
    logic [3:0] d1_yr, d0_yr, d1_hht, d0_hht, d1_mmt, d0_mmt, d1_sst, d0_sst;
    logic       am_pm, formato_hora, estado_alarma, update_done, bcd_err;
    logic [7:0] dia_semana;

    always #5 clock = ~clock;

    rtc_display_regs #(.ALARM_TIMEOUT_CYC(TMO), .CNT_W(32)) dut (
        .clock(clock), .reset(reset), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .commit(commit), .alarm_ack(alarm_ack), .vsync(vsync),
        .digit1_HH(d1_hh), .digit0_HH(d0_hh), .digit1_MM(d1_mm), .digit0_MM(d0_mm),
        .digit1_SS(d1_ss), .digit0_SS(d0_ss), .digit1_DAY(d1_day), .digit0_DAY(d0_day),
        .digit1_MES(d1_mes), .digit0_MES(d0_mes), .digit1_YEAR(d1_yr), .digit0_YEAR(d0_yr),
        .digit1_HH_T(d1_hht), .digit0_HH_T(d0_hht), .digit1_MM_T(d1_mmt), .digit0_MM_T(d0_mmt),
        .digit1_SS_T(d1_sst), .digit0_SS_T(d0_sst),
        .AM_PM(am_pm), .dia_semana(dia_semana), .formato_hora(formato_hora),
        .estado_alarma(estado_alarma), .update_done(update_done), .bcd_err(bcd_err)
    );

    logic [71:0] dut_digits;
    assign dut_digits = {d1_ss, d0_ss, d1_mm, d0_mm, d1_hh, d0_hh, d1_day, d0_day,
                         d1_mes, d0_mes, d1_yr, d0_yr, d1_sst, d0_sst, d1_mmt, d0_mmt,
                         d1_hht, d0_hht};

    int checks = 0;
    int errors = 0;
    bit cmp_en = 1'b0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    logic [7:0] m_shadow[10], m_snap[10], m_out[9];
    logic       m_shadow_fmt, m_snap_fmt;
    logic [7:0] m_wday;
    logic       m_fmt, m_ampm, m_alarm, m_done, m_err;
    int         m_stage;
    bit         m_pending;
    longint     cyc, set_cyc;

    function automatic bit f_valid(input int idx, input logic [7:0] b);
        int t, u, v;
        if (idx == 9) return (b >= 8'd1) && (b <= 8'd7);
        t = int'(b[7:4]);
        u = int'(b[3:0]);
        if (t > 9 || u > 9) return 1'b0;
        v = t * 10 + u;
        case (idx)
            0, 1, 6, 7: return v <= 59;
            2, 8:       return v <= 23;
            3:          return v >= 1 && v <= 31;
            4:          return v >= 1 && v <= 12;
            default:    return 1'b1;
        endcase
    endfunction

    function automatic logic [7:0] f_bcd(input int v);
        logic [7:0] r;
        r[7:4] = 4'(v / 10);
        r[3:0] = 4'(v % 10);
        return r;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 10; i++) begin
            m_shadow[i] = 8'd0;
            m_snap[i]   = 8'd0;
        end
        for (int i = 0; i < 9; i++) m_out[i] = 8'd0;
        m_shadow[9] = 8'd1; m_snap[9] = 8'd1;
        m_shadow_fmt = 1'b0; m_snap_fmt = 1'b0;
        m_wday = 8'd1; m_fmt = 1'b0; m_ampm = 1'b0; m_alarm = 1'b0;
        m_done = 1'b0; m_err = 1'b0; m_stage = 0; m_pending = 1'b0;
    endtask

    task automatic take_snapshot();
        for (int i = 0; i < 10; i++) m_snap[i] = m_shadow[i];
        m_snap_fmt = m_shadow_fmt;
    endtask

    task automatic model_apply(output bit set);
        bit old_nz, any_err;
        int v, h;
        old_nz  = (m_out[6] | m_out[7] | m_out[8]) != 8'd0;
        any_err = 1'b0;
        for (int i = 0; i < 9; i++) begin
            if (!f_valid(i, m_snap[i])) begin
                any_err = 1'b1;
            end else if (i == 2) begin
                v = int'(m_snap[2][7:4]) * 10 + int'(m_snap[2][3:0]);
                if (m_snap_fmt) begin
                    h = v % 12;
                    if (h == 0) h = 12;
                    m_out[2] = f_bcd(h);
                    m_ampm   = (v >= 12);
                end else begin
                    m_out[2] = m_snap[2];
                    m_ampm   = 1'b0;
                end
            end else begin
                m_out[i] = m_snap[i];
            end
        end
        if (f_valid(9, m_snap[9])) m_wday = m_snap[9];
        else any_err = 1'b1;
        m_fmt  = m_snap_fmt;
        m_done = 1'b1;
        m_err  = any_err;
        set    = old_nz && ((m_out[6] | m_out[7] | m_out[8]) == 8'd0);
    endtask

    always @(posedge clock or posedge reset) begin
        bit set;
        if (reset) begin
            model_reset();
        end else begin
            cyc++;
            m_done = 1'b0;
            m_err  = 1'b0;
            set    = 1'b0;
            case (m_stage)
                2: begin
                    model_apply(set);
                    if (m_pending || commit) begin
                        take_snapshot();
                        m_pending = 1'b0;
                        m_stage   = 1;
                    end else begin
                        m_stage = 0;
                    end
                end
                1: begin
                    if (commit) m_pending = 1'b1;
                    m_stage = 2;
                end
                default: if (commit) begin
                    take_snapshot();
                    m_stage = 1;
                end
            endcase
            if (set) begin
                m_alarm = 1'b1;
                set_cyc = cyc;
            end else if (m_alarm && (alarm_ack || (cyc - set_cyc) >= longint'(TMO))) begin
                m_alarm = 1'b0;
            end
            if (wr_en) begin
                if (wr_addr <= 4'd9)       m_shadow[wr_addr] = wr_data;
                else if (wr_addr == 4'd10) m_shadow_fmt = wr_data[0];
            end
        end
    end

    always @(negedge clock) begin
        logic [71:0] md;
        if (cmp_en) begin
            for (int i = 0; i < 9; i++) md[8*(8-i) +: 8] = m_out[i];
            check("digits", dut_digits, md);
            check("am_pm", am_pm, m_ampm);
            check("dia_semana", dia_semana, m_wday);
            check("formato_hora", formato_hora, m_fmt);
            check("estado_alarma", estado_alarma, m_alarm);
            check("update_done", update_done, m_done);
            check("bcd_err", bcd_err, m_err);
        end
    end

    // ---------------- stimulus ----------------
    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic wr(input logic [3:0] a, input logic [7:0] d);
        wr_en = 1'b1; wr_addr = a; wr_data = d;
        step();
        wr_en = 1'b0;
    endtask

    // Leaves time just after edge T+2, where the committed outputs must be visible.
    task automatic commit_wait();
        commit = 1'b1;
        step();
        commit = 1'b0;
        step();
        check("latency_t1_no_done", update_done, 1'b0);
        step();
        check("latency_t2_done", update_done, 1'b1);
    endtask

    function automatic logic [7:0] gen_data(input logic [3:0] a);
        if ($urandom_range(7) == 0) return 8'($urandom);
        case (a)
            4'd0, 4'd1: return f_bcd($urandom_range(59));
            4'd2:       return f_bcd($urandom_range(23));
            4'd3:       return f_bcd($urandom_range(31, 1));
            4'd4:       return f_bcd($urandom_range(12, 1));
            4'd5:       return f_bcd($urandom_range(99));
            4'd6, 4'd7: return ($urandom_range(2) == 0) ? f_bcd($urandom_range(59)) : 8'h00;
            4'd8:       return ($urandom_range(2) == 0) ? f_bcd($urandom_range(23)) : 8'h00;
            4'd9:       return 8'($urandom_range(7, 1));
            default:    return 8'($urandom);
        endcase
    endfunction

    initial begin
        logic [7:0] hh_in  [5] = '{8'h00, 8'h11, 8'h12, 8'h13, 8'h23};
        logic [7:0] hh_exp [5] = '{8'h12, 8'h11, 8'h12, 8'h01, 8'h11};
        logic       pm_exp [5] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
        int pulses;

        reset = 1'b1; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
        commit = 1'b0; alarm_ack = 1'b0; vsync = 1'b1;
        repeat (3) @(posedge clock);
        #1 reset = 1'b0;
        cmp_en = 1'b1;

        check("reset_digits", dut_digits, 72'd0);
        check("reset_wday", dia_semana, 8'd1);
        check("reset_alarm", estado_alarma, 1'b0);
        check("reset_am_pm", am_pm, 1'b0);

        // Day and month must be non-zero to pass validation.
        wr(4'd3, 8'h01);
        wr(4'd4, 8'h01);
        wr(4'd2, 8'h17);
        wr(4'd10, 8'h01);
        commit_wait();
        check("hh17_12h", {d1_hh, d0_hh}, 8'h05);
        check("hh17_pm", am_pm, 1'b1);
        check("hh17_no_err", bcd_err, 1'b0);
        step();
        check("single_pulse", update_done, 1'b0);

        for (int i = 0; i < 5; i++) begin
            wr(4'd2, hh_in[i]);
            commit_wait();
            check("hh_12h_boundary", {d1_hh, d0_hh}, hh_exp[i]);
            check("ampm_boundary", am_pm, pm_exp[i]);
            step();
        end

        wr(4'd10, 8'h00);
        wr(4'd2, 8'h23);
        commit_wait();
        check("hh23_24h", {d1_hh, d0_hh}, 8'h23);
        check("hh23_24h_am", am_pm, 1'b0);
        check("fmt_24h", formato_hora, 1'b0);
        step();

        wr(4'd1, 8'h25);
        commit_wait();
        check("mm25", {d1_mm, d0_mm}, 8'h25);
        check("mm25_no_err", bcd_err, 1'b0);
        step();
        wr(4'd1, 8'h5A);
        wr(4'd3, 8'h15);
        commit_wait();
        check("mm5a_held", {d1_mm, d0_mm}, 8'h25);
        check("day_updates", {d1_day, d0_day}, 8'h15);
        check("mm5a_err", bcd_err, 1'b1);
        step();
        wr(4'd1, 8'h60);
        wr(4'd5, 8'h24);
        commit_wait();
        check("mm60_held", {d1_mm, d0_mm}, 8'h25);
        check("year_updates", {d1_yr, d0_yr}, 8'h24);
        check("mm60_err", bcd_err, 1'b1);
        step();

        wr(4'd6, 8'h01);
        commit_wait();
        check("timer_nz_no_alarm", estado_alarma, 1'b0);
        wr(4'd6, 8'h00);
        commit_wait();
        check("timer_zero_alarm", estado_alarma, 1'b1);
        alarm_ack = 1'b1;
        step();
        alarm_ack = 1'b0;
        check("alarm_ack_clears", estado_alarma, 1'b0);
        commit_wait();
        check("zero_twice_no_alarm", estado_alarma, 1'b0);
        wr(4'd6, 8'h01);
        commit_wait();
        wr(4'd6, 8'h00);
        commit_wait();
        repeat (9) step();
        check("alarm_before_timeout", estado_alarma, 1'b1);
        step();
        check("alarm_timeout", estado_alarma, 1'b0);

        wr(4'd0, 8'h11);
        commit_wait();
        step();
        pulses = 0;
        commit = 1'b1;
        step();
        pulses += int'(update_done);
        wr_en = 1'b1; wr_addr = 4'd0; wr_data = 8'h42;
        step();
        pulses += int'(update_done);
        wr_en = 1'b0;
        step();
        pulses += int'(update_done);
        commit = 1'b0;
        repeat (6) begin
            step();
            pulses += int'(update_done);
        end
        check("held_commit_pulses", pulses, 2);
        check("held_commit_ss", {d1_ss, d0_ss}, 8'h42);

        wr(4'd0, 8'h33);
        commit = 1'b1;
        step();
        commit = 1'b0;
        reset = 1'b1;
        step();
        reset = 1'b0;
        pulses = 0;
        repeat (5) begin
            step();
            pulses += int'(update_done);
        end
        check("reset_convert_no_done", pulses, 0);
        check("reset_convert_digits", dut_digits, 72'd0);
        check("reset_convert_wday", dia_semana, 8'd1);

        for (int n = 0; n < 3000; n++) begin
            wr_en     = ($urandom_range(1) == 1);
            wr_addr   = 4'($urandom_range(15));
            wr_data   = gen_data(wr_addr);
            commit    = ($urandom_range(7) == 0);
            alarm_ack = ($urandom_range(39) == 0);
            vsync     = 1'($urandom_range(1));
            step();
        end
        wr_en = 1'b0; commit = 1'b0; alarm_ack = 1'b0;
        repeat (5) step();
        cmp_en = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/rtc_display_regs.md
Name: rtc_display_regs

Overview:
- Upstream feeder of the VGA clock-screen top.
- Receives BCD time/date/timer bytes and control bits from the RTC read/config logic over a simple write port. Holds them in shadow registers and commits them atomically to the display digit outputs.
- On commit, applies 12/24 h conversion with AM/PM generation, validates BCD, and raises the alarm flag when the countdown timer reaches 00:00:00.

Parameters:
- ALARM_TIMEOUT_CYC, 32'd3000000000, clock cycles after which `estado_alarma` self-clears (30 s at 100 MHz); 0 disables auto-clear.
- CNT_W, 32, width of the alarm timeout counter.

Ports:
- clock  in  1  system clock (100 MHz)
- reset  in  1  asynchronous, active-high
- wr_en  in  1  write strobe, one byte per cycle
- wr_addr  in  4  register address (map below)
- wr_data  in  8  BCD byte: [7:4] = tens, [3:0] = units
- commit  in  1  single-cycle pulse; request transfer of shadow registers to the outputs
- alarm_ack  in  1  clears `estado_alarma`
- vsync  in  1  VGA vsync, active-low; used only with SHADOW_VSYNC_EN
- digit1_X / digit0_X  out  4 each  tens/units digits for X in {HH, MM, SS, DAY, MES, YEAR, HH_T, MM_T, SS_T}; 18 outputs
- AM_PM  out  1  0 = AM, 1 = PM; meaningful only when formato_hora = 1
- dia_semana  out  8  weekday, 1 to 7 (1 = Monday)
- formato_hora  out  1  0 = 24 h, 1 = 12 h
- estado_alarma  out  1  timer-expired flag
- update_done  out  1  one-cycle pulse when the outputs change
- bcd_err  out  1  one-cycle pulse with update_done if any field was rejected

Behaviour:
- Address map:
  - 0 SS, 1 MM, 2 HH, 3 DAY, 4 MES, 5 YEAR, 6 SS_T, 7 MM_T, 8 HH_T.
  - 9 dia_semana (binary).
  - 10 control: bit0 = formato_hora.
  - 11 to 15: write ignored.
- Writes update shadow registers only. They never affect the outputs directly.
- Reset values:
  - All digit outputs 0, AM_PM 0, dia_semana 8'd1, formato_hora 0.
  - estado_alarma 0, update_done 0, bcd_err 0.
  - All shadow registers equal their output reset values. FSM in IDLE.
- FSM states and transitions:
  - IDLE: on commit, snapshot shadow into working registers and go to CONVERT.
  - CONVERT: run validation and the 12 h conversion; go to APPLY.
  - APPLY: load outputs, pulse update_done, return to IDLE.
- Latency: commit sampled at edge T; outputs and update_done valid after edge T+2.
- Write timing: writes in the same cycle as commit are NOT in the snapshot. Later writes go to the next commit.
- commit arriving while in CONVERT or APPLY sets a pending bit. The FSM re-enters CONVERT from APPLY, so no commit is lost. Multiple pending commits collapse to one.
- Validation, per field:
  - Reject if any nibble > 9.
  - Reject if a range is exceeded: HH/HH_T > 23, MM/SS/MM_T/SS_T > 59, DAY not 1 to 31, MES not 1 to 12, dia_semana not 1 to 7.
  - A rejected field keeps its previous output value; bcd_err pulses.
- 12 h conversion, applied to HH only, when the snapshotted formato_hora = 1:
  - 00 → 12, AM_PM 0.
  - 01 to 11 → unchanged, AM_PM 0.
  - 12 → 12, AM_PM 1.
  - 13 to 23 → HH − 12, AM_PM 1.
  - Arithmetic is done in binary (tens×10 + units) and converted back to BCD.
- In 24 h mode HH passes through and AM_PM is forced to 0. The timer hours are never converted.
- Alarm set: in APPLY, if the previous committed timer was non-zero and the new timer is 00:00:00 → set estado_alarma.
  - Committing 00:00:00 twice in a row does not re-trigger.
  - Alarm set is independent of bcd_err for other fields. If a timer field is rejected, the held value is used for the comparison.
- Alarm clear: by alarm_ack, or when the timeout counter reaches ALARM_TIMEOUT_CYC−1. The counter runs only while the flag is set and resets to 0 on every set.
- Set and ack in the same cycle: set wins.
- Reset mid-operation: FSM returns to IDLE, the pending commit is dropped, and no update_done is issued.

Optional Feature:
- SHADOW_VSYNC_EN defined:
  - An accepted commit enters WAIT_FRAME instead of CONVERT. The snapshot is still taken at accept.
  - WAIT_FRAME advances to CONVERT on the first vsync falling edge, detected by a registered compare.
  - Outputs therefore change only at frame start, so there is no torn digits.
  - Latency = edge detect + 2 cycles.
  - commit during WAIT_FRAME sets pending and re-snapshots at APPLY.
- Not defined: the vsync input is ignored and there is no WAIT_FRAME state.

Decomposition:
- Package rtc_display_pkg holds:
  - Register address constants (ADDR_SS to ADDR_CTRL).
  - FSM state encoding.
  - Field limit constants (HH_MAX = 23, MM_MAX = 59, and the rest).
  - The BCD digit-pair typedef.
- One natural sub-module, bcd_hour_12h: combinational BCD validation plus the 24→12 h conversion. Inputs: 8-bit BCD hour and format bit. Outputs: 8-bit BCD hour, am_pm, err.

Test Plan:
- Reset → all digits 0, dia_semana 1, estado_alarma 0. Write HH = 8'h17, ctrl = 1, then commit → at T+2: digit1_HH = 0, digit0_HH = 5, AM_PM = 1, update_done pulses once.
- 12 h boundaries: HH = 00, 11, 12, 13, 23 → 12/AM, 11/AM, 12/PM, 01/PM, 11/PM. ctrl = 0 with HH = 23 → 23, AM_PM = 0.
- Invalid data: MM = 8'h5A, then MM = 8'h60, each committed → digits_MM hold their previous value, bcd_err pulses with update_done, and the other fields update.
- Timer: commit 00:00:01, then commit 00:00:00 → estado_alarma = 1 at T+2. A repeat commit of 00:00:00 does not re-pulse. alarm_ack → 0 on the next cycle. With ALARM_TIMEOUT_CYC = 10 and no ack → clears after 10 cycles.
- Commit held high 3 cycles; write SS = 8'h42 in the middle cycle → exactly two update_done pulses; final digits_SS = 4/2.
- Reset asserted in CONVERT → no update_done and outputs stay at reset values. With SHADOW_VSYNC_EN, commit → outputs change only after the next vsync falling edge.
